vigenere_cipher: RTL and testbench

- Combinational Vigenère encryptor for one 8-bit ASCII character.
- Holds a 4-character key and a key-index counter that advances on each rising edge of a slow shift strobe.
- Sits inside the keyboard-to-VGA datapath. The datapath loads the key bytes, toggles the shift strobe once per keystroke pair, and samples char_out for display.

---
 rtl/vigenere_pkg.sv | 36 +++
 rtl/vigenere_char_shift.sv | 49 ++++
 rtl/vigenere_cipher.sv | 82 ++++++++
 tb/tb_vigenere_cipher.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vigenere_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vigenere_pkg
//  Description : ASCII constants and letter/shift helper functions shared by
//                the Vigenere cipher datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package vigenere_pkg;

    localparam logic [7:0] ASCII_UC_A  = 8'h41;
    localparam logic [7:0] ASCII_UC_Z  = 8'h5A;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [5:0] ALPHA_LEN   = 6'd26;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_UC_A) && (c <= ASCII_UC_Z);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_LC_A) && (c <= ASCII_LC_Z);
    endfunction

    // 'A'/'a' both have 5'b00001 in their low bits, so for any letter the
    // alphabet position is simply low5 - 1, independent of case.
    function automatic logic [4:0] key_shift(input logic [7:0] k);
        if (is_upper(k) || is_lower(k)) begin
            return k[4:0] - 5'd1;
        end
        return 5'd0;
    endfunction

endpackage : vigenere_pkg
`default_nettype wire

// File: rtl/vigenere_char_shift.sv
`default_nettype none
// ============================================================================
//  Module      : vigenere_char_shift
//  Description : Combinational Caesar shift of one ASCII character by 0..25,
//                case preserving; non-letters pass through unchanged.
//                Optional macro VIGENERE_DECRYPT_EN adds a decrypt input that
//                applies the inverse shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module vigenere_char_shift
    import vigenere_pkg::*;
(
    input  logic [7:0] char_in,
    input  logic [4:0] shift,
`ifdef VIGENERE_DECRYPT_EN
    input  logic       decrypt,
`endif
    output logic [7:0] char_out
);

    logic       letter;
    logic [7:0] base;
    logic [4:0] offset;
    logic [5:0] sum;
    logic [5:0] wrapped;

    // Rotate the alphabet position and rebuild the character in its own case.
    always_comb begin
        letter  = is_upper(char_in) || is_lower(char_in);
        base    = is_upper(char_in) ? ASCII_UC_A : ASCII_LC_A;
        // Both bases end in 5'b00001, so position = low5 - 1 for either case.
        offset  = char_in[4:0] - 5'd1;
`ifdef VIGENERE_DECRYPT_EN
        if (decrypt) begin
            // Adding 26 - s keeps the sum non-negative (max 25 + 26 = 51).
            sum = {1'b0, offset} + (ALPHA_LEN - {1'b0, shift});
        end else begin
            sum = {1'b0, offset} + {1'b0, shift};
        end
`else
        sum     = {1'b0, offset} + {1'b0, shift};
`endif
        // Sum never reaches 52, so one conditional subtract is a full mod 26.
        wrapped  = (sum >= ALPHA_LEN) ? (sum - ALPHA_LEN) : sum;
        char_out = letter ? (base + {2'b00, wrapped}) : char_in;
    end

endmodule : vigenere_char_shift
`default_nettype wire

// File: rtl/vigenere_cipher.sv
`default_nettype none
// ============================================================================
//  Module      : vigenere_cipher
//  Description : Vigenere encryptor for one ASCII character. Holds a key-index
//                counter advanced by rising edges of a slow asynchronous
//                strobe (2-flop synchronizer + edge detect). The ciphertext
//                output is combinational from char_in, key_arr and the index.
//                Optional macro VIGENERE_DECRYPT_EN adds a decrypt input.
//  Revision    : 1.0 - initial release
// ============================================================================
module vigenere_cipher
    import vigenere_pkg::*;
#(
    parameter  int KEY_LEN = 4,
    localparam int IDX_W   = $clog2(KEY_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 keyboard_clk,
    input  logic [8*KEY_LEN-1:0] key_arr,
    input  logic [7:0]           char_in,
`ifdef VIGENERE_DECRYPT_EN
    input  logic                 decrypt,
`endif
    output logic [7:0]           char_out,
    output logic [IDX_W-1:0]     IDX_out
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q,  prev_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             strobe_rise;
    logic [7:0]       key_byte;
    logic [4:0]       shift;

    // Synchronizer chain, edge-detect history and wrapping index counter.
    always_comb begin
        sync1_d     = keyboard_clk;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        strobe_rise = sync2_q && !prev_q;
        idx_d       = idx_q;
        if (strobe_rise) begin
            idx_d = (idx_q == IDX_W'(KEY_LEN - 1)) ? '0 : (idx_q + IDX_W'(1));
        end
    end

    // State registers; an active-low reset overrides any pending edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            idx_q   <= idx_d;
        end
    end

    // Select the active key byte and convert it to a shift amount.
    always_comb begin
        key_byte = key_arr[{idx_q, 3'b000} +: 8];
        shift    = key_shift(key_byte);
    end

    vigenere_char_shift u_char_shift (
        .char_in  (char_in),
        .shift    (shift),
`ifdef VIGENERE_DECRYPT_EN
        .decrypt  (decrypt),
`endif
        .char_out (char_out)
    );

    assign IDX_out = idx_q;

endmodule : vigenere_cipher
`default_nettype wire

// File: tb/tb_vigenere_cipher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vigenere_cipher
//  Description : Self-checking bench for vigenere_cipher: directed scenarios
//                with literal expectations, then randomized traffic checked
//                every cycle against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vigenere_cipher;

    localparam int KEY_LEN = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 keyboard_clk;
    logic [8*KEY_LEN-1:0] key_arr;
    logic [7:0]           char_in;
    logic                 dec;
    logic [7:0]           char_out;
    logic [1:0]           IDX_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: expected index and strobe edges still in flight
    // (each entry = posedges remaining until the index must move).
    int exp_idx = 0;
    int pending[$];

    always #10 clk = ~clk;

    vigenere_cipher #(.KEY_LEN(KEY_LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .keyboard_clk (keyboard_clk),
        .key_arr      (key_arr),
        .char_in      (char_in),
`ifdef VIGENERE_DECRYPT_EN
        .decrypt      (dec),
`endif
        .char_out     (char_out),
        .IDX_out      (IDX_out)
    );

    function automatic logic [7:0] model_char(input logic [7:0] c, input logic [7:0] k, input logic d);
        int s;
        int base;
        s = 0;
        if (k >= 8'h41 && k <= 8'h5A) s = int'(k) - 65;
        else if (k >= 8'h61 && k <= 8'h7A) s = int'(k) - 97;
        if (c >= 8'h41 && c <= 8'h5A) base = 65;
        else if (c >= 8'h61 && c <= 8'h7A) base = 97;
        else return c;
        if (d) return 8'(base + ((int'(c) - base) - s + 26) % 26);
        return 8'(base + ((int'(c) - base) + s) % 26);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: per-cycle comparison on the falling edge, model
    // update on the rising edge, then return 1 time unit later for driving.
    task automatic tick();
        int nxt[$];
        logic d;
        @(negedge clk);
`ifdef VIGENERE_DECRYPT_EN
        d = dec;
`else
        d = 1'b0;
`endif
        check("cycle_idx", int'(IDX_out), exp_idx);
        check("cycle_char", int'(char_out),
              int'(model_char(char_in, key_arr[8*exp_idx +: 8], d)));
        @(posedge clk);
        if (!reset) begin
            exp_idx = 0;
            pending.delete();
        end else begin
            nxt.delete();
            foreach (pending[i]) begin
                if (pending[i] == 1) exp_idx = (exp_idx + 1) % KEY_LEN;
                else nxt.push_back(pending[i] - 1);
            end
            pending = nxt;
        end
        #1;
    endtask

    task automatic set_kb(input logic v);
        if (v && !keyboard_clk && reset) pending.push_back(3);
        keyboard_clk = v;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        if (keyboard_clk) pending.push_back(3);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ticks(2);
        release_reset();
        tick();
    endtask

    function automatic logic [7:0] rand_key_byte();
        case ($urandom_range(0, 3))
            0:       return 8'(8'h41 + $urandom_range(0, 25));
            1:       return 8'(8'h61 + $urandom_range(0, 25));
            2:       return 8'($urandom_range(0, 255));
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 4))
            0, 1:    return 8'(8'h41 + $urandom_range(0, 25));
            2, 3:    return 8'(8'h61 + $urandom_range(0, 25));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int kb_left;
        reset        = 1'b0;
        keyboard_clk = 1'b0;
        key_arr      = 32'h5359454B;   // "KEYS", byte 0 = 'K'
        char_in      = 8'h68;          // 'h'
        dec          = 1'b0;

        // Output is live during reset with index 0.
        ticks(3);
        check("reset_idx", int'(IDX_out), 0);
        check("reset_char_h_K", int'(char_out), 8'h72);
        release_reset();
        tick();

        // First strobe edge: exactly three clocks to the index change.
        char_in = 8'h45;               // 'E'
        set_kb(1'b1);
        tick();
        check("lat_cycle1", int'(IDX_out), 0);
        tick();
        check("lat_cycle2", int'(IDX_out), 0);
        tick();
        check("lat_cycle3", int'(IDX_out), 1);
        check("char_E_E", int'(char_out), 8'h49);
        set_kb(1'b0);
        ticks(4);
        check("fall_ignored", int'(IDX_out), 1);

        // Index 2 uses 'Y' (s=24): wrap and pass-through.
        set_kb(1'b1); ticks(3); set_kb(1'b0); ticks(2);
        check("idx_two", int'(IDX_out), 2);
        char_in = 8'h7A;
        tick();
        check("wrap_z_Y", int'(char_out), 8'h78);
        char_in = 8'h20;
        tick();
        check("space_pass", int'(char_out), 8'h20);

        // Reset coincident with a detected edge wins; next edge gives 1.
        set_kb(1'b1);
        ticks(2);
        reset = 1'b0;
        set_kb(1'b0);
        tick();
        check("reset_wins", int'(IDX_out), 0);
        release_reset();
        ticks(4);
        check("after_reset_hold", int'(IDX_out), 0);
        set_kb(1'b1); ticks(3);
        check("edge_after_reset", int'(IDX_out), 1);
        set_kb(1'b0); ticks(2);

        // Four edges from index 0 walk 1,2,3,0.
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            set_kb(1'b1); ticks(3);
            check("walk_idx", int'(IDX_out), e % 4);
            set_kb(1'b0); ticks(2);
        end
        key_arr = '0;
        char_in = 8'h51;
        tick();
        check("zero_key_Q", int'(char_out), 8'h51);

        // Strobe already high at reset release counts as one edge.
        key_arr = 32'h5359454B;
        reset   = 1'b0;
        set_kb(1'b1);
        ticks(2);
        release_reset();
        ticks(2);
        check("high_at_release_pre", int'(IDX_out), 0);
        tick();
        check("high_at_release", int'(IDX_out), 1);
        set_kb(1'b0); ticks(2);

`ifdef VIGENERE_DECRYPT_EN
        do_reset();
        dec     = 1'b1;
        char_in = 8'h72;
        tick();
        check("decrypt_r_K", int'(char_out), 8'h68);
        dec = 1'b0;
        tick();
`endif

        // Randomized traffic.
        do_reset();
        kb_left = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            char_in = rand_char();
            if ($urandom_range(0, 9) == 0) begin
                for (int b = 0; b < KEY_LEN; b++) key_arr[8*b +: 8] = rand_key_byte();
            end
`ifdef VIGENERE_DECRYPT_EN
            dec = 1'($urandom_range(0, 1));
`endif
            if (kb_left == 0) begin
                set_kb(!keyboard_clk);
                kb_left = $urandom_range(1, 5);
            end else begin
                kb_left--;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_vigenere_cipher
`default_nettype wire
